// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback > multi-cycle buffer > host debug.
// A starvation FSM raises stall_req so a buffered multi-cycle result drains.
//
// state   | meaning
// S_NORM  | counting denied cycles of a full buffer, stall_req low
// S_STALL | buffered result starved too long, stall_req high until MC grant
module rf_write_arbiter #(
    parameter int   STARVE_LIMIT = 4,
    parameter logic EXEC_STATE   = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [2:0]  mc_addr,
    input  logic [15:0] mc_data,
    input  logic        dbg_req,
    input  logic [2:0]  dbg_addr,
    input  logic [15:0] dbg_data,
    output logic        dbg_ack,
    output logic        stall_req,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data
);

    typedef enum logic {S_NORM, S_STALL} starve_t;

    starve_t     starve_state;
    logic [3:0]  starve_cnt;
    logic [3:0]  cnt_inc;
    logic        cnt_reach;

    logic        buf_full;
    logic [2:0]  buf_addr;
    logic [15:0] buf_data;

    logic        gnt_wb;
    logic        gnt_mc;
    logic        gnt_dbg;

    // Fixed-priority grant; dbg_ack high blocks a second grant on a held request.
    always_comb begin
        gnt_wb  = wb_we && (state == EXEC_STATE);
        gnt_mc  = !gnt_wb && buf_full;
        gnt_dbg = !gnt_wb && !buf_full && dbg_req && (state != EXEC_STATE) && !dbg_ack;
    end

    // Saturating increment and limit compare for the starvation counter.
    always_comb begin
        cnt_inc   = (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
        cnt_reach = ({1'b0, starve_cnt} + 5'd1) >= 5'(STARVE_LIMIT);
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= 3'd0;
            wr_data <= 16'd0;
            dbg_ack <= 1'b0;
        end else begin
            wr_en   <= gnt_wb || gnt_mc || gnt_dbg;
            dbg_ack <= gnt_dbg;
            if (gnt_wb) begin
                wr_addr <= wb_addr;
                wr_data <= wb_data;
            end else if (gnt_mc) begin
                wr_addr <= buf_addr;
                wr_data <= buf_data;
            end else if (gnt_dbg) begin
                wr_addr <= dbg_addr;
                wr_data <= dbg_data;
            end
        end
    end

    // One-entry holding buffer for the multi-cycle unit; drain and capture are exclusive.
    always_ff @(posedge clock) begin
        if (!reset) begin
            buf_full <= 1'b0;
            buf_addr <= 3'd0;
            buf_data <= 16'd0;
            mc_ready <= 1'b0;
        end else if (gnt_mc) begin
            buf_full <= 1'b0;
            mc_ready <= 1'b1;
        end else if (mc_valid && mc_ready) begin
            buf_full <= 1'b1;
            buf_addr <= mc_addr;
            buf_data <= mc_data;
            mc_ready <= 1'b0;
        end else begin
            mc_ready <= !buf_full;
        end
    end

    // Starvation FSM: count denied cycles of a full buffer, stall the pipeline at the limit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            starve_state <= S_NORM;
            starve_cnt   <= 4'd0;
            stall_req    <= 1'b0;
        end else begin
            case (starve_state)
                S_NORM: begin
                    if (gnt_mc) begin
                        starve_cnt <= 4'd0;
                    end else if (buf_full) begin
                        starve_cnt <= cnt_inc;
                        if (cnt_reach) begin
                            starve_state <= S_STALL;
                            stall_req    <= 1'b1;
                        end
                    end
                end
                S_STALL: begin
                    if (gnt_mc) begin
                        starve_state <= S_NORM;
                        starve_cnt   <= 4'd0;
                        stall_req    <= 1'b0;
                    end else if (buf_full) begin
                        starve_cnt <= cnt_inc;
                    end
                end
                default: begin
                    starve_state <= S_NORM;
                    starve_cnt   <= 4'd0;
                    stall_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single register-file write port (gr0..gr7) and shares it between three requesters:
  - the pipeline writeback stage;
  - a multi-cycle functional unit (valid/ready handshake, one-entry holding buffer);
  - a host debug port.
- The writeback stage has absolute priority because it can never be stalled.
- A starvation counter raises a pipeline stall request so the buffered multi-cycle result eventually drains.

Parameters:
- STARVE_LIMIT, 4, consecutive denied cycles of a full buffer before stall_req asserts (legal range 1..15).
- EXEC_STATE, 1'b1, value of the state input meaning "CPU executing".

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- state  input  1  CPU run state; equals EXEC_STATE while executing
- wb_we  input  1  writeback stage requests a register write this cycle
- wb_addr  input  3  writeback destination register
- wb_data  input  16  writeback data
- mc_valid  input  1  multi-cycle unit presents a result
- mc_ready  output  1  arbiter can accept a multi-cycle result
- mc_addr  input  3  multi-cycle destination register
- mc_data  input  16  multi-cycle result
- dbg_req  input  1  host write request, level, held until dbg_ack
- dbg_addr  input  3  host destination register
- dbg_data  input  16  host write data
- dbg_ack  output  1  one-cycle pulse, host write performed
- stall_req  output  1  asks the pipeline to bubble writeback
- wr_en  output  1  register-file write enable
- wr_addr  output  3  register-file write address
- wr_data  output  16  register-file write data

Behaviour:
- Reset: sampled on the clock edge while reset=0. Resulting values:
  - wr_en=0, wr_addr=0, wr_data=0
  - dbg_ack=0, stall_req=0, mc_ready=0
  - buffer empty, starve counter=0, FSM in S_NORM
- mc_ready goes to 1 on the first edge after reset releases.
- Reset mid-operation discards buffered data without writing it.
- Output timing: wr_en/wr_addr/wr_data are registered. A grant decided in cycle N appears in cycle N+1 for exactly one cycle. When nothing is granted, wr_en=0 and addr/data hold their last values.
- Eligibility each cycle:
  - WB is eligible iff wb_we=1 and state==EXEC_STATE.
  - MC is eligible iff the buffer is full, in any state.
  - DBG is eligible iff dbg_req=1, state!=EXEC_STATE, and dbg_ack=0 in the current cycle. This prevents a double grant on a held request.
- Priority: WB > MC > DBG. Exactly one grant per cycle.
- MC handshake:
  - mc_ready is registered and equals NOT buffer-full.
  - A transfer occurs when mc_valid=1 and mc_ready=1 at the edge; addr/data are captured into the buffer.
  - The buffer clears on the edge where MC is granted; mc_ready returns to 1 the following cycle.
  - Maximum MC throughput is one result per 2 cycles. Capture and drain never occur in the same cycle.
- Debug: dbg_ack is asserted in the same cycle as the corresponding wr_en. A dbg_req pending when state enters EXEC_STATE waits until state leaves it.
- Starvation FSM:
  - S_NORM: the counter increments each cycle the buffer is full and MC is not granted, saturating at 15. When counter+1 reaches STARVE_LIMIT, go to S_STALL and register stall_req=1 from the next cycle.
  - S_STALL: stall_req=1. The pipeline must deassert wb_we from the following cycle. If wb_we is still asserted, WB still wins; WB is never dropped. On MC grant, go to S_NORM, clear stall_req and the counter on the same edge.
  - The counter clears on any MC grant.
- Same address written by WB and buffered MC in one cycle: WB writes first, MC writes later. The later write wins by design; the scheduler guarantees MC results are younger.
- No combinational path from any input to any output.

Test Plan:
- Reset then idle: hold reset=0 two cycles, release → all outputs 0, mc_ready=1 on the first cycle after release, wr_en stays 0 with no requests.
- WB only: state=1, wb_we=1, wb_addr=3, wb_data=16'hBEEF for one cycle → next cycle wr_en=1, wr_addr=3, wr_data=16'hBEEF; the cycle after, wr_en=0.
- MC vs WB contention with STARVE_LIMIT=4:
  - Setup: mc_valid with addr 5, data 16'h1234 captured; wb_we held 1 continuously.
  - Response: stall_req=1 after 4 denied cycles.
  - Then drop wb_we: the next cycle MC is granted and wr_addr=5, wr_data=16'h1234; stall_req=0 and mc_ready=1 one cycle later.
- Debug gating: dbg_req=1, addr 7, data 16'h00FF while state=1 → no dbg_ack. Switch state=0 → one cycle later wr_en=1, wr_addr=7, dbg_ack=1 for exactly one cycle, even though dbg_req is still held for one more cycle.
- Three-way tie with state=0: MC buffered and dbg_req=1 with wb_we ignored → MC is written first, DBG the next grant cycle. Back-to-back mc_valid → second acceptance no earlier than 2 cycles after the first.
- Reset mid-operation: buffer full and stall_req=1, apply reset=0 for one edge → stall_req=0, no wr_en for the discarded entry, mc_ready=1 after release.
